// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, forwarding select
// and a saturating stall counter for a classic 5-stage MIPS-style pipeline.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_read_data_1,
  input  logic [31:0] id_read_data_2,
  input  logic [31:0] id_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_to_reg,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_reg_dst,
  input  logic        id_alu_src,
  input  logic        id_branch,
  input  logic [2:0]  id_alu_op,
  input  logic        flush,
  input  logic        ex_mem_reg_write,
  input  logic [4:0]  ex_mem_rd,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_rd,
  output logic        ex_valid,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [31:0] ex_read_data_1,
  output logic [31:0] ex_read_data_2,
  output logic [31:0] ex_imm,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_dst,
  output logic        ex_alu_src,
  output logic        ex_branch,
  output logic [2:0]  ex_alu_op,
  output logic [4:0]  ex_write_reg,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        stall,
  output logic        pc_write,
  output logic        if_id_write,
  output logic [15:0] stall_count
);

  logic load_use;
  logic bubble;
  logic exm_ok;
  logic mwb_ok;

  // A load in EX whose destination feeds the instruction in ID must wait one
  // cycle; a flush discards that instruction anyway, so it suppresses the stall.
  assign load_use = ex_valid && ex_mem_read && (ex_rt != 5'd0) && id_valid &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign stall       = load_use && !flush;
  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign bubble      = stall || flush || !id_valid;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid       <= 1'b0;
      ex_rs          <= 5'd0;
      ex_rt          <= 5'd0;
      ex_read_data_1 <= 32'd0;
      ex_read_data_2 <= 32'd0;
      ex_imm         <= 32'd0;
      ex_reg_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_dst     <= 1'b0;
      ex_alu_src     <= 1'b0;
      ex_branch      <= 1'b0;
      ex_alu_op      <= 3'b000;
      ex_write_reg   <= 5'd0;
    end else begin
      ex_valid       <= 1'b1;
      ex_rs          <= id_rs;
      ex_rt          <= id_rt;
      ex_read_data_1 <= id_read_data_1;
      ex_read_data_2 <= id_read_data_2;
      ex_imm         <= id_imm;
      ex_reg_write   <= id_reg_write;
      ex_mem_to_reg  <= id_mem_to_reg;
      ex_mem_read    <= id_mem_read;
      ex_mem_write   <= id_mem_write;
      ex_reg_dst     <= id_reg_dst;
      ex_alu_src     <= id_alu_src;
      ex_branch      <= id_branch;
      ex_alu_op      <= id_alu_op;
      ex_write_reg   <= id_reg_dst ? id_rd : id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= 16'd0;
    else if (stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end

  // Register $0 is never a real producer; the younger EX/MEM result wins.
  assign exm_ok = ex_mem_reg_write && (ex_mem_rd != 5'd0);
  assign mwb_ok = mem_wb_reg_write && (mem_wb_rd != 5'd0);

  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (ex_valid) begin
      if (exm_ok && (ex_mem_rd == ex_rs))      ForwardA = 2'b10;
      else if (mwb_ok && (mem_wb_rd == ex_rs)) ForwardA = 2'b01;
      if (exm_ok && (ex_mem_rd == ex_rt))      ForwardB = 2'b10;
      else if (mwb_ok && (mem_wb_rd == ex_rt)) ForwardB = 2'b01;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table walked in order, plus
// hand sequences for forwarding variants, counter saturation and reset mid-stall.
module tb_id_ex_stage;

  localparam logic [6:0] ALU_C = 7'b1000100; // {rw,m2r,mr,mw,dst,asrc,br}
  localparam logic [6:0] LW_C  = 7'b1110010;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_read_data_1, id_read_data_2, id_imm;
  logic [6:0]  id_ctrl;
  logic [2:0]  id_alu_op;
  logic        flush;
  logic        ex_mem_reg_write, mem_wb_reg_write;
  logic [4:0]  ex_mem_rd, mem_wb_rd;

  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_write_reg;
  logic [31:0] ex_read_data_1, ex_read_data_2, ex_imm;
  logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic        ex_reg_dst, ex_alu_src, ex_branch;
  logic [2:0]  ex_alu_op;
  logic [1:0]  ForwardA, ForwardB;
  logic        stall, pc_write, if_id_write;
  logic [15:0] stall_count;
  logic [6:0]  ex_ctrl;

  assign ex_ctrl = {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                    ex_reg_dst, ex_alu_src, ex_branch};

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2), .id_imm(id_imm),
    .id_reg_write(id_ctrl[6]), .id_mem_to_reg(id_ctrl[5]), .id_mem_read(id_ctrl[4]),
    .id_mem_write(id_ctrl[3]), .id_reg_dst(id_ctrl[2]), .id_alu_src(id_ctrl[1]),
    .id_branch(id_ctrl[0]), .id_alu_op(id_alu_op), .flush(flush),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_read_data_1(ex_read_data_1), .ex_read_data_2(ex_read_data_2), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_write_reg(ex_write_reg),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .stall(stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic [6:0]  ctrl;
    logic [2:0]  alu;
    logic        fl;
    logic        exm_rw;
    logic [4:0]  exm_rd;
    logic        mwb_rw;
    logic [4:0]  mwb_rd;
    logic        e_stall;   // combinational, before the edge
    logic [1:0]  e_fa, e_fb;
    logic        e_valid;   // registered, after the edge
    logic [4:0]  e_wr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  function automatic vec_t mk(input string name, input logic valid,
                              input logic [4:0] rs, rt, rd,
                              input logic [31:0] rd1, rd2, imm,
                              input logic [6:0] ctrl, input logic [2:0] alu, input logic fl,
                              input logic exm_rw, input logic [4:0] exm_rd,
                              input logic mwb_rw, input logic [4:0] mwb_rd,
                              input logic e_stall, input logic [1:0] e_fa, e_fb,
                              input logic e_valid, input logic [4:0] e_wr,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.name = name; v.valid = valid; v.rs = rs; v.rt = rt; v.rd = rd;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.ctrl = ctrl; v.alu = alu; v.fl = fl;
    v.exm_rw = exm_rw; v.exm_rd = exm_rd; v.mwb_rw = mwb_rw; v.mwb_rd = mwb_rd;
    v.e_stall = e_stall; v.e_fa = e_fa; v.e_fb = e_fb;
    v.e_valid = e_valid; v.e_wr = e_wr; v.e_cnt = e_cnt;
    return v;
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: expected queue empty, got 0x%0h", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, act, e);
    end
  endtask

  // drivers
  task automatic drive(input vec_t v);
    id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_read_data_1 = v.rd1; id_read_data_2 = v.rd2; id_imm = v.imm;
    id_ctrl = v.ctrl; id_alu_op = v.alu; flush = v.fl;
    ex_mem_reg_write = v.exm_rw; ex_mem_rd = v.exm_rd;
    mem_wb_reg_write = v.mwb_rw; mem_wb_rd = v.mwb_rd;
  endtask

  task automatic drive_instr(input logic valid, input logic [4:0] rs, rt, rd,
                             input logic [31:0] rd1, input logic [6:0] ctrl);
    drive(mk("", valid, rs, rt, rd, rd1, 32'h0, 32'h0, ctrl, 3'b000, 1'b0,
             1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 16'd0));
  endtask

  task automatic check_comb(input vec_t v);
    chk({v.name, ".stall"}, stall, v.e_stall);
    chk({v.name, ".pc_write"}, pc_write, !v.e_stall);
    chk({v.name, ".if_id_write"}, if_id_write, !v.e_stall);
    chk({v.name, ".ForwardA"}, ForwardA, v.e_fa);
    chk({v.name, ".ForwardB"}, ForwardB, v.e_fb);
  endtask

  task automatic check_ex(input vec_t v);
    exp_q.push_back({31'd0, v.e_valid});
    exp_q.push_back(v.e_valid ? {27'd0, v.rs} : 32'd0);
    exp_q.push_back(v.e_valid ? {27'd0, v.rt} : 32'd0);
    exp_q.push_back(v.e_valid ? v.rd1 : 32'd0);
    exp_q.push_back(v.e_valid ? v.rd2 : 32'd0);
    exp_q.push_back(v.e_valid ? v.imm : 32'd0);
    exp_q.push_back(v.e_valid ? {25'd0, v.ctrl} : 32'd0);
    exp_q.push_back(v.e_valid ? {29'd0, v.alu} : 32'd0);
    exp_q.push_back({27'd0, v.e_wr});
    exp_q.push_back({16'd0, v.e_cnt});
    chk_q({v.name, ".ex_valid"}, {31'd0, ex_valid});
    chk_q({v.name, ".ex_rs"}, {27'd0, ex_rs});
    chk_q({v.name, ".ex_rt"}, {27'd0, ex_rt});
    chk_q({v.name, ".ex_read_data_1"}, ex_read_data_1);
    chk_q({v.name, ".ex_read_data_2"}, ex_read_data_2);
    chk_q({v.name, ".ex_imm"}, ex_imm);
    chk_q({v.name, ".ex_ctrl"}, {25'd0, ex_ctrl});
    chk_q({v.name, ".ex_alu_op"}, {29'd0, ex_alu_op});
    chk_q({v.name, ".ex_write_reg"}, {27'd0, ex_write_reg});
    chk_q({v.name, ".stall_count"}, {16'd0, stall_count});
  endtask

  initial begin
    vecs.push_back(mk("pass", 1, 1, 2, 3, 32'h5, 32'h7, 32'h20, ALU_C, 3'b010, 0,
                      0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 3, 16'd0));
    vecs.push_back(mk("lw_in", 1, 1, 2, 0, 32'h100, 32'h0, 32'h4, LW_C, 3'b000, 0,
                      1, 2, 1, 1, 0, 2'b01, 2'b10, 1, 2, 16'd0));
    vecs.push_back(mk("load_use", 1, 2, 5, 6, 32'h11, 32'h22, 32'h0, ALU_C, 3'b010, 0,
                      0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 16'd1));
    vecs.push_back(mk("replay", 1, 2, 5, 6, 32'h11, 32'h22, 32'h0, ALU_C, 3'b010, 0,
                      1, 2, 0, 0, 0, 2'b00, 2'b00, 1, 6, 16'd1));
    vecs.push_back(mk("lw_rt0", 1, 3, 0, 0, 32'h8, 32'h0, 32'hc, LW_C, 3'b000, 0,
                      1, 5, 1, 2, 0, 2'b01, 2'b10, 1, 0, 16'd1));
    vecs.push_back(mk("no_false_stall", 1, 0, 0, 7, 32'h1, 32'h2, 32'h0, ALU_C, 3'b010, 0,
                      0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 7, 16'd1));
    vecs.push_back(mk("lw_r4", 1, 1, 4, 0, 32'h40, 32'h0, 32'h10, LW_C, 3'b000, 0,
                      1, 0, 1, 0, 0, 2'b00, 2'b00, 1, 4, 16'd1));
    vecs.push_back(mk("flush_prio", 1, 9, 4, 8, 32'h99, 32'h44, 32'h0, ALU_C, 3'b010, 1,
                      0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd1));
    vecs.push_back(mk("lw_r4_again", 1, 1, 4, 0, 32'h40, 32'h0, 32'h10, LW_C, 3'b000, 0,
                      0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 4, 16'd1));
    vecs.push_back(mk("id_invalid", 0, 4, 4, 8, 32'h1, 32'h2, 32'h3, ALU_C, 3'b010, 0,
                      0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd1));
    vecs.push_back(mk("add_r4", 1, 4, 4, 8, 32'h3, 32'h4, 32'h0, ALU_C, 3'b010, 0,
                      0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 8, 16'd1));
    vecs.push_back(mk("fwd_prio", 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 7'd0, 3'b000, 0,
                      1, 4, 1, 4, 0, 2'b10, 2'b10, 0, 0, 16'd1));

    // reset with every ID input nonzero
    rst = 1'b1;
    drive(mk("", 1, 5, 6, 7, 32'hAAAA, 32'hBBBB, 32'hCCCC, 7'h7F, 3'b111, 0,
             1, 5, 1, 6, 0, 2'b00, 2'b00, 0, 0, 16'd0));
    repeat (2) @(posedge clk);
    #1;
    check_ex(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 2'b00, 2'b00, 0, 0, 16'd0));
    check_comb(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  0, 2'b00, 2'b00, 0, 0, 16'd0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_comb(vecs[i]);
      @(posedge clk);
      #1;
      check_ex(vecs[i]);
    end

    // forwarding variants with ex_rs = ex_rt = 4
    @(negedge clk);
    drive_instr(1, 4, 4, 8, 32'h0, ALU_C);
    @(posedge clk);
    @(negedge clk);
    drive_instr(0, 0, 0, 0, 32'h0, 7'd0);
    ex_mem_reg_write = 1; ex_mem_rd = 4; mem_wb_reg_write = 1; mem_wb_rd = 4;
    #1;
    chk("fwd_both.ForwardA", ForwardA, 2'b10);
    ex_mem_reg_write = 0;
    #1;
    chk("fwd_memwb.ForwardA", ForwardA, 2'b01);
    chk("fwd_memwb.ForwardB", ForwardB, 2'b01);
    ex_mem_reg_write = 1; ex_mem_rd = 0; mem_wb_rd = 0;
    #1;
    chk("fwd_zero.ForwardA", ForwardA, 2'b00);
    chk("fwd_zero.ForwardB", ForwardB, 2'b00);

    // counter saturation: preset near the top, then two load-use stalls
    force dut.stall_count = 16'hFFFE;
    #1;
    release dut.stall_count;
    @(posedge clk); #1;
    chk("sat_preset_hold", stall_count, 16'hFFFE);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_instr(1, 1, 2, 0, 32'h100, LW_C);
      @(posedge clk);
      @(negedge clk);
      drive_instr(1, 2, 5, 6, 32'h11, ALU_C);
      #1;
      chk($sformatf("sat_stall%0d.stall", k), stall, 1'b1);
      @(posedge clk); #1;
      chk($sformatf("sat_stall%0d.count", k), stall_count, 16'hFFFF);
    end

    // reset arriving while a load-use stall is pending
    @(negedge clk);
    drive_instr(1, 1, 2, 0, 32'h100, LW_C);
    @(posedge clk);
    @(negedge clk);
    drive_instr(1, 2, 5, 6, 32'h11, ALU_C);
    rst = 1'b1;
    #1;
    chk("rst_mid.stall_before", stall, 1'b1);
    @(posedge clk); #1;
    chk("rst_mid.ex_valid", ex_valid, 1'b0);
    chk("rst_mid.stall_count", stall_count, 16'd0);
    chk("rst_mid.stall_after", stall, 1'b0);
    chk("rst_mid.ex_mem_read", ex_mem_read, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.ex_valid", ex_valid, 1'b1);
    chk("post_rst.ex_read_data_1", ex_read_data_1, 32'h11);
    chk("post_rst.ex_write_reg", ex_write_reg, 5'd6);
    chk("post_rst.stall_count", stall_count, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
